// File: rtl/gerenciador_requisicao_caminho.sv
// ---------------------------------------------------------------------------
// gerenciador_requisicao_caminho
//
// Host-side manager for the path-search engine. It forwards host obstacle-map
// writes to the engine, launches source/destination requests, collects the
// path nodes the engine emits (destination first, source last) into a LIFO,
// and then delivers them to the host in source->destination order.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   host_obst_*               obstacle write channel from host (valid/ready)
//   host_req_*                path request channel from host (valid/ready)
//   host_caminho_*            path delivery channel to host (valid/ready/last)
//   obstaculos_wr_*           registered obstacle write port to the engine
//   top_wr_fonte_out          one-cycle launch pulse to the engine
//   top_addr_fonte/destino    latched request addresses to the engine
//   gma_read_data_in/pronto   path nodes emitted by the engine
//   ocupado_out               high whenever a request is in progress
//   erro_overflow/timeout     sticky error flags, cleared by the next request
// ---------------------------------------------------------------------------
module gerenciador_requisicao_caminho #(
    parameter int ADDR_WIDTH    = 10,
    parameter int MAX_CAMINHO   = 64,
    parameter int TIMEOUT_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  host_obst_valid_in,
    output logic                  host_obst_ready_out,
    input  logic [ADDR_WIDTH-1:0] host_obst_addr_in,
    input  logic                  host_obst_data_in,
    input  logic                  host_req_valid_in,
    output logic                  host_req_ready_out,
    input  logic [ADDR_WIDTH-1:0] host_fonte_in,
    input  logic [ADDR_WIDTH-1:0] host_destino_in,
    output logic                  host_caminho_valid_out,
    input  logic                  host_caminho_ready_in,
    output logic [ADDR_WIDTH-1:0] host_caminho_data_out,
    output logic                  host_caminho_last_out,
    output logic                  obstaculos_wr_enable_out,
    output logic [ADDR_WIDTH-1:0] obstaculos_wr_addr_out,
    output logic                  obstaculos_wr_data_out,
    output logic                  top_wr_fonte_out,
    output logic [ADDR_WIDTH-1:0] top_addr_fonte_out,
    output logic [ADDR_WIDTH-1:0] top_addr_destino_out,
    input  logic [ADDR_WIDTH-1:0] gma_read_data_in,
    input  logic                  gma_pronto_in,
    output logic                  ocupado_out,
    output logic                  erro_overflow_out,
    output logic                  erro_timeout_out
);

    localparam int IDX_W = $clog2(MAX_CAMINHO);
    localparam int PTR_W = IDX_W + 1;

    localparam logic [1:0] OCIOSO   = 2'd0;
    localparam logic [1:0] INICIAR  = 2'd1;
    localparam logic [1:0] AGUARDAR = 2'd2;
    localparam logic [1:0] ENTREGAR = 2'd3;

    // Watchdog trips on the idle cycle that would bring it to all-ones.
    localparam logic [TIMEOUT_WIDTH-1:0] WD_LIMITE = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

    logic [1:0]               estado;
    logic [PTR_W-1:0]         ptr;
    logic [TIMEOUT_WIDTH-1:0] watchdog;
    logic [ADDR_WIDTH-1:0]    pilha [MAX_CAMINHO];

    logic aceita_obst;
    logic aceita_req;
    logic empilha;
    logic pilha_cheia;
    logic eh_fonte;
    logic entrega_aceita;
    logic [IDX_W-1:0] idx_prox;

    // Ready signals come straight from the state; an obstacle write takes
    // priority over a request arriving in the same cycle.
    assign host_obst_ready_out = (estado == OCIOSO);
    assign host_req_ready_out  = (estado == OCIOSO) && !host_obst_valid_in;
    assign top_wr_fonte_out    = (estado == INICIAR);
    assign ocupado_out         = (estado != OCIOSO);

    assign aceita_obst    = host_obst_valid_in && host_obst_ready_out;
    assign aceita_req     = host_req_valid_in && host_req_ready_out;
    assign empilha        = (estado == AGUARDAR) && gma_pronto_in;
    assign pilha_cheia    = (ptr == PTR_W'(MAX_CAMINHO));
    assign eh_fonte       = (gma_read_data_in == top_addr_fonte_out);
    assign entrega_aceita = host_caminho_valid_out && host_caminho_ready_in;
    // Slot below the beat being accepted now, i.e. stack[ptr-2]; modular
    // arithmetic on the low bits gives the right slot even when ptr is full.
    assign idx_prox       = ptr[IDX_W-1:0] - IDX_W'(2);

    // Obstacle writes are forwarded to the engine one cycle after acceptance,
    // one enable pulse per accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            obstaculos_wr_enable_out <= 1'b0;
            obstaculos_wr_addr_out   <= '0;
            obstaculos_wr_data_out   <= 1'b0;
        end else begin
            obstaculos_wr_enable_out <= aceita_obst;
            if (aceita_obst) begin
                obstaculos_wr_addr_out <= host_obst_addr_in;
                obstaculos_wr_data_out <= host_obst_data_in;
            end
        end
    end

    // Path LIFO storage. No reset: contents are only meaningful below ptr.
    // A push into a full stack is an overflow and never written.
    always_ff @(posedge clk) begin
        if (empilha && !pilha_cheia) begin
            pilha[ptr[IDX_W-1:0]] <= gma_read_data_in;
        end
    end

    // Main sequencer: launch the request, collect nodes until the source
    // shows up, then pop them back out towards the host.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado                 <= OCIOSO;
            ptr                    <= '0;
            watchdog               <= '0;
            top_addr_fonte_out     <= '0;
            top_addr_destino_out   <= '0;
            erro_overflow_out      <= 1'b0;
            erro_timeout_out       <= 1'b0;
            host_caminho_valid_out <= 1'b0;
            host_caminho_data_out  <= '0;
            host_caminho_last_out  <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (aceita_req) begin
                        top_addr_fonte_out   <= host_fonte_in;
                        top_addr_destino_out <= host_destino_in;
                        erro_overflow_out    <= 1'b0;
                        erro_timeout_out     <= 1'b0;
                        ptr                  <= '0;
                        watchdog             <= '0;
                        estado               <= INICIAR;
                    end
                end

                INICIAR: begin
                    estado <= AGUARDAR;
                end

                AGUARDAR: begin
                    if (gma_pronto_in) begin
                        watchdog <= '0;
                        // With MAX_CAMINHO nodes already stored there is no
                        // room left for anything, so any further node aborts.
                        if (pilha_cheia) begin
                            erro_overflow_out <= 1'b1;
                            estado            <= OCIOSO;
                        end else begin
                            ptr <= ptr + PTR_W'(1);
                            if (eh_fonte) begin
                                // The source is the top of stack, so it is
                                // also the first beat handed to the host.
                                host_caminho_valid_out <= 1'b1;
                                host_caminho_data_out  <= gma_read_data_in;
                                host_caminho_last_out  <= (ptr == '0);
                                estado                 <= ENTREGAR;
                            end
                        end
                    end else if (watchdog == WD_LIMITE) begin
                        watchdog         <= '0;
                        erro_timeout_out <= 1'b1;
                        estado           <= OCIOSO;
                    end else begin
                        watchdog <= watchdog + TIMEOUT_WIDTH'(1);
                    end
                end

                ENTREGAR: begin
                    if (entrega_aceita) begin
                        ptr <= ptr - PTR_W'(1);
                        if (host_caminho_last_out) begin
                            host_caminho_valid_out <= 1'b0;
                            host_caminho_last_out  <= 1'b0;
                            estado                 <= OCIOSO;
                        end else begin
                            host_caminho_data_out <= pilha[idx_prox];
                            host_caminho_last_out <= (ptr == PTR_W'(2));
                        end
                    end
                end

                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gerenciador_requisicao_caminho.sv
// ---------------------------------------------------------------------------
// tb_gerenciador_requisicao_caminho
//
// Directed bench for gerenciador_requisicao_caminho with a small LIFO
// (MAX_CAMINHO=4) and a short watchdog (TIMEOUT_WIDTH=4). Inputs change and
// outputs are sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_gerenciador_requisicao_caminho;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          host_obst_valid_in;
    logic          host_obst_ready_out;
    logic [AW-1:0] host_obst_addr_in;
    logic          host_obst_data_in;
    logic          host_req_valid_in;
    logic          host_req_ready_out;
    logic [AW-1:0] host_fonte_in;
    logic [AW-1:0] host_destino_in;
    logic          host_caminho_valid_out;
    logic          host_caminho_ready_in;
    logic [AW-1:0] host_caminho_data_out;
    logic          host_caminho_last_out;
    logic          obstaculos_wr_enable_out;
    logic [AW-1:0] obstaculos_wr_addr_out;
    logic          obstaculos_wr_data_out;
    logic          top_wr_fonte_out;
    logic [AW-1:0] top_addr_fonte_out;
    logic [AW-1:0] top_addr_destino_out;
    logic [AW-1:0] gma_read_data_in;
    logic          gma_pronto_in;
    logic          ocupado_out;
    logic          erro_overflow_out;
    logic          erro_timeout_out;

    int checks = 0;
    int errors = 0;
    int pulsos_fonte = 0;

    gerenciador_requisicao_caminho #(
        .ADDR_WIDTH   (AW),
        .MAX_CAMINHO  (4),
        .TIMEOUT_WIDTH(4)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .host_obst_valid_in      (host_obst_valid_in),
        .host_obst_ready_out     (host_obst_ready_out),
        .host_obst_addr_in       (host_obst_addr_in),
        .host_obst_data_in       (host_obst_data_in),
        .host_req_valid_in       (host_req_valid_in),
        .host_req_ready_out      (host_req_ready_out),
        .host_fonte_in           (host_fonte_in),
        .host_destino_in         (host_destino_in),
        .host_caminho_valid_out  (host_caminho_valid_out),
        .host_caminho_ready_in   (host_caminho_ready_in),
        .host_caminho_data_out   (host_caminho_data_out),
        .host_caminho_last_out   (host_caminho_last_out),
        .obstaculos_wr_enable_out(obstaculos_wr_enable_out),
        .obstaculos_wr_addr_out  (obstaculos_wr_addr_out),
        .obstaculos_wr_data_out  (obstaculos_wr_data_out),
        .top_wr_fonte_out        (top_wr_fonte_out),
        .top_addr_fonte_out      (top_addr_fonte_out),
        .top_addr_destino_out    (top_addr_destino_out),
        .gma_read_data_in        (gma_read_data_in),
        .gma_pronto_in           (gma_pronto_in),
        .ocupado_out             (ocupado_out),
        .erro_overflow_out       (erro_overflow_out),
        .erro_timeout_out        (erro_timeout_out)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Counts launch pulses seen by the engine at each active edge.
    always @(posedge clk) begin
        if (top_wr_fonte_out === 1'b1) pulsos_fonte <= pulsos_fonte + 1;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL global_timeout observed=running required=finished");
        $fatal(1, "[TB] simulation time bound expired");
    end

    // Advance n clock edges, landing 1 unit after the last one.
    task automatic applyStimulus(input int ciclos);
        repeat (ciclos) @(posedge clk);
        #1;
    endtask

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst                   = 1'b1;
        host_obst_valid_in    = 1'b0;
        host_obst_addr_in     = '0;
        host_obst_data_in     = 1'b0;
        host_req_valid_in     = 1'b0;
        host_fonte_in         = '0;
        host_destino_in       = '0;
        host_caminho_ready_in = 1'b0;
        gma_read_data_in      = '0;
        gma_pronto_in         = 1'b0;

        // Reset state
        applyStimulus(2);
        checkOutput("rst_ocupado", ocupado_out, 0);
        checkOutput("rst_wr_en", obstaculos_wr_enable_out, 0);
        checkOutput("rst_fonte", top_addr_fonte_out, 0);
        checkOutput("rst_destino", top_addr_destino_out, 0);
        checkOutput("rst_ovf", erro_overflow_out, 0);
        checkOutput("rst_tmo", erro_timeout_out, 0);
        checkOutput("rst_valid", host_caminho_valid_out, 0);
        rst = 1'b0;
        applyStimulus(1);
        checkOutput("idle_obst_ready", host_obst_ready_out, 1);
        checkOutput("idle_req_ready", host_req_ready_out, 1);

        // Three back-to-back obstacle writes, also blocking the request ready
        host_obst_valid_in = 1'b1;
        host_obst_data_in  = 1'b1;
        host_obst_addr_in  = 10'd5;
        host_req_valid_in  = 1'b1;
        host_fonte_in      = 10'd100;
        #1;
        checkOutput("obst_wins_req_ready", host_req_ready_out, 0);
        applyStimulus(1);
        checkOutput("wr1_en", obstaculos_wr_enable_out, 1);
        checkOutput("wr1_addr", obstaculos_wr_addr_out, 5);
        checkOutput("wr1_data", obstaculos_wr_data_out, 1);
        checkOutput("wr1_ocupado", ocupado_out, 0);
        host_obst_addr_in = 10'd6;
        applyStimulus(1);
        checkOutput("wr2_en", obstaculos_wr_enable_out, 1);
        checkOutput("wr2_addr", obstaculos_wr_addr_out, 6);
        host_obst_addr_in = 10'd7;
        applyStimulus(1);
        checkOutput("wr3_en", obstaculos_wr_enable_out, 1);
        checkOutput("wr3_addr", obstaculos_wr_addr_out, 7);
        host_obst_valid_in = 1'b0;
        host_req_valid_in  = 1'b0;
        applyStimulus(1);
        checkOutput("wr_en_drop", obstaculos_wr_enable_out, 0);
        checkOutput("req_not_taken", ocupado_out, 0);

        // Request 2 -> 9, four-node path (exactly MAX_CAMINHO)
        host_req_valid_in = 1'b1;
        host_fonte_in     = 10'd2;
        host_destino_in   = 10'd9;
        applyStimulus(1);
        checkOutput("iniciar_pulse", top_wr_fonte_out, 1);
        checkOutput("iniciar_fonte", top_addr_fonte_out, 2);
        checkOutput("iniciar_destino", top_addr_destino_out, 9);
        checkOutput("iniciar_ocupado", ocupado_out, 1);
        host_req_valid_in = 1'b0;
        applyStimulus(1);
        checkOutput("aguardar_pulse_low", top_wr_fonte_out, 0);
        checkOutput("aguardar_obst_ready", host_obst_ready_out, 0);
        gma_pronto_in    = 1'b1;
        gma_read_data_in = 10'd9;
        applyStimulus(1);
        gma_read_data_in = 10'd8;
        applyStimulus(1);
        gma_pronto_in = 1'b0;
        applyStimulus(1);
        gma_pronto_in    = 1'b1;
        gma_read_data_in = 10'd4;
        applyStimulus(1);
        checkOutput("no_beat_before_src", host_caminho_valid_out, 0);
        gma_read_data_in = 10'd2;
        applyStimulus(1);
        gma_pronto_in = 1'b0;
        checkOutput("full_path_ovf", erro_overflow_out, 0);
        checkOutput("beat0_valid", host_caminho_valid_out, 1);
        checkOutput("beat0_data", host_caminho_data_out, 2);
        checkOutput("beat0_last", host_caminho_last_out, 0);

        // Delivery with host ready 1,0,0,1,1,1
        host_caminho_ready_in = 1'b1;
        applyStimulus(1);
        checkOutput("beat1_data", host_caminho_data_out, 4);
        host_caminho_ready_in = 1'b0;
        applyStimulus(1);
        checkOutput("stall1_data", host_caminho_data_out, 4);
        checkOutput("stall1_valid", host_caminho_valid_out, 1);
        applyStimulus(1);
        checkOutput("stall2_data", host_caminho_data_out, 4);
        checkOutput("stall2_last", host_caminho_last_out, 0);
        host_caminho_ready_in = 1'b1;
        applyStimulus(1);
        checkOutput("beat2_data", host_caminho_data_out, 8);
        checkOutput("beat2_last", host_caminho_last_out, 0);
        applyStimulus(1);
        checkOutput("beat3_data", host_caminho_data_out, 9);
        checkOutput("beat3_last", host_caminho_last_out, 1);
        applyStimulus(1);
        host_caminho_ready_in = 1'b0;
        checkOutput("done_valid", host_caminho_valid_out, 0);
        checkOutput("done_ocupado", ocupado_out, 0);
        checkOutput("done_obst_ready", host_obst_ready_out, 1);
        checkOutput("one_launch_pulse", pulsos_fonte, 1);

        // pronto while idle is ignored
        gma_pronto_in    = 1'b1;
        gma_read_data_in = 10'd2;
        applyStimulus(2);
        gma_pronto_in = 1'b0;
        checkOutput("idle_pronto_ignored", ocupado_out, 0);
        checkOutput("idle_pronto_valid", host_caminho_valid_out, 0);

        // Single-node path, fonte == destino == 3
        host_req_valid_in = 1'b1;
        host_fonte_in     = 10'd3;
        host_destino_in   = 10'd3;
        applyStimulus(1);
        host_req_valid_in = 1'b0;
        applyStimulus(1);
        gma_pronto_in    = 1'b1;
        gma_read_data_in = 10'd3;
        applyStimulus(1);
        gma_pronto_in = 1'b0;
        checkOutput("single_valid", host_caminho_valid_out, 1);
        checkOutput("single_data", host_caminho_data_out, 3);
        checkOutput("single_last", host_caminho_last_out, 1);
        host_caminho_ready_in = 1'b1;
        applyStimulus(1);
        host_caminho_ready_in = 1'b0;
        checkOutput("single_done_valid", host_caminho_valid_out, 0);
        checkOutput("single_done_ocupado", ocupado_out, 0);

        // Overflow: five nodes that never match fonte=1
        host_req_valid_in = 1'b1;
        host_fonte_in     = 10'd1;
        host_destino_in   = 10'd20;
        applyStimulus(1);
        host_req_valid_in = 1'b0;
        applyStimulus(1);
        gma_pronto_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            gma_read_data_in = AW'(20 + i);
            applyStimulus(1);
        end
        checkOutput("ovf_4th_flag", erro_overflow_out, 0);
        checkOutput("ovf_4th_ocupado", ocupado_out, 1);
        gma_read_data_in = 10'd24;
        applyStimulus(1);
        gma_pronto_in = 1'b0;
        checkOutput("ovf_flag", erro_overflow_out, 1);
        checkOutput("ovf_ocupado", ocupado_out, 0);
        checkOutput("ovf_no_beat", host_caminho_valid_out, 0);
        applyStimulus(1);
        checkOutput("ovf_sticky", erro_overflow_out, 1);

        // Timeout: next request clears overflow, then no pronto
        host_req_valid_in = 1'b1;
        host_fonte_in     = 10'd1;
        host_destino_in   = 10'd2;
        applyStimulus(1);
        host_req_valid_in = 1'b0;
        checkOutput("ovf_cleared", erro_overflow_out, 0);
        applyStimulus(1);
        applyStimulus(14);
        checkOutput("tmo_14_flag", erro_timeout_out, 0);
        checkOutput("tmo_14_ocupado", ocupado_out, 1);
        applyStimulus(1);
        checkOutput("tmo_15_flag", erro_timeout_out, 1);
        checkOutput("tmo_15_ocupado", ocupado_out, 0);

        // Reset in the middle of delivery
        host_req_valid_in = 1'b1;
        host_fonte_in     = 10'd3;
        host_destino_in   = 10'd5;
        applyStimulus(1);
        host_req_valid_in = 1'b0;
        checkOutput("tmo_cleared", erro_timeout_out, 0);
        applyStimulus(1);
        gma_pronto_in    = 1'b1;
        gma_read_data_in = 10'd5;
        applyStimulus(1);
        gma_read_data_in = 10'd3;
        applyStimulus(1);
        gma_pronto_in = 1'b0;
        checkOutput("mid_valid", host_caminho_valid_out, 1);
        checkOutput("mid_data", host_caminho_data_out, 3);
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        checkOutput("midrst_valid", host_caminho_valid_out, 0);
        checkOutput("midrst_ocupado", ocupado_out, 0);
        checkOutput("midrst_obst_ready", host_obst_ready_out, 1);
        checkOutput("midrst_fonte", top_addr_fonte_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
